control_unit: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 59 +++++
 rtl/cu_decoder.sv | 25 ++
 rtl/control_unit.sv | 175 +++++++++++++++++
 tb/tb_control_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU opcodes,
// state codes, instruction classes and the opcode-to-ALU-op mapping.
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b01110;

  // Codes are visible on state_T, so they are fixed rather than tool-chosen.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOADI,
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

  function automatic logic [4:0] alu_op_of(input logic [4:0] opcode);
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_op_of = ALU_ADD;
      OP_SUB:                                alu_op_of = ALU_SUB;
      OP_AND, OP_ANDI:                       alu_op_of = ALU_AND;
      OP_OR, OP_ORI:                         alu_op_of = ALU_OR;
      default:                               alu_op_of = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decode: instruction class for the sequencer plus the
// ALU opcode used in the execute step.
module cu_decoder
  import cpu_defs_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t instr_class,
  output logic [4:0]   alu_op
);

  always_comb begin
    alu_op = alu_op_of(opcode);
    case (opcode)
      OP_LDI:                         instr_class = CLS_LOADI;
      OP_LD:                          instr_class = CLS_LOAD;
      OP_ST:                          instr_class = CLS_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  instr_class = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       instr_class = CLS_ITYPE;
      OP_NOP:                         instr_class = CLS_NOP;
      OP_HALT:                        instr_class = CLS_HALT;
      default:                        instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch in T0-T2, per-class execute in T3-T7.
// Every datapath control output is a pure decode of state and opcode.
module control_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_Data,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        ba_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        illegal_op,
  output logic [3:0]  state_T
);

  state_t       state, state_next;
  instr_class_t instr_class;
  logic [4:0]   alu_op;
  logic [26:0]  ir_unused;

  // Only the opcode field steers the sequencer; operand fields go to the datapath.
  assign ir_unused = IR_Data[26:0];

  cu_decoder u_decoder (
    .opcode      (IR_Data[31:27]),
    .instr_class (instr_class),
    .alu_op      (alu_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= state_t'(RESET_STATE);
    else       state <= state_next;
  end

  assign state_T = state;
  assign run     = (state != ST_IDLE) && (state != ST_HALT);

  always_comb begin
    state_next          = state;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    ba_select           = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    alu_instruction     = 5'b00000;
    illegal_op          = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_T0;
      ST_T0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
        state_next = ST_T1;
      end
      ST_T1: begin
        PC_increment_enable = 1'b1;
        read                = 1'b1;
        MDR_enable          = 1'b1;
        state_next          = ST_T2;
      end
      ST_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
        state_next = ST_T3;
      end
      ST_T3: begin
        state_next = ST_T4;
        case (instr_class)
          CLS_LOADI, CLS_LOAD, CLS_STORE: begin
            Grb       = 1'b1;
            ba_select = 1'b1;
            Y_enable  = 1'b1;
          end
          CLS_RTYPE: begin
            Grb      = 1'b1;
            r_select = 1'b1;
            Y_enable = 1'b1;
          end
          CLS_ITYPE: begin
            c_select = 1'b1;
            Y_enable = 1'b1;
          end
          CLS_HALT: state_next = ST_HALT;
          CLS_ILLEGAL: begin
            illegal_op = 1'b1;
            state_next = ST_T0;
          end
          default: state_next = ST_T0;
        endcase
      end
      ST_T4: begin
        Z_enable        = 1'b1;
        alu_instruction = alu_op;
        state_next      = ST_T5;
        case (instr_class)
          CLS_RTYPE: begin
            Grc      = 1'b1;
            r_select = 1'b1;
          end
          CLS_ITYPE: begin
            Grb      = 1'b1;
            r_select = 1'b1;
          end
          default: c_select = 1'b1;
        endcase
      end
      ST_T5: begin
        Z_LO_select = 1'b1;
        // Memory instructions use the computed address; the rest write back.
        if (instr_class == CLS_LOAD || instr_class == CLS_STORE) begin
          MAR_enable = 1'b1;
          state_next = ST_T6;
        end else begin
          Gra        = 1'b1;
          r_enable   = 1'b1;
          state_next = ST_T0;
        end
      end
      ST_T6: begin
        MDR_enable = 1'b1;
        state_next = ST_T7;
        if (instr_class == CLS_LOAD) begin
          read = 1'b1;
        end else begin
          Gra      = 1'b1;
          r_select = 1'b1;
        end
      end
      ST_T7: begin
        state_next = ST_T0;
        if (instr_class == CLS_LOAD) begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-instruction microstep model fills an
// expected queue of control words that is checked every cycle, plus literal probes.
module tb_control_unit;

  localparam int CW = 29;

  localparam logic [17:0] M_PCI    = 18'h1 << 17;
  localparam logic [17:0] M_IR     = 18'h1 << 16;
  localparam logic [17:0] M_Y      = 18'h1 << 15;
  localparam logic [17:0] M_Z      = 18'h1 << 14;
  localparam logic [17:0] M_MAR    = 18'h1 << 13;
  localparam logic [17:0] M_MDR    = 18'h1 << 12;
  localparam logic [17:0] M_REN    = 18'h1 << 11;
  localparam logic [17:0] M_RD     = 18'h1 << 10;
  localparam logic [17:0] M_WR     = 18'h1 << 9;
  localparam logic [17:0] M_GRA    = 18'h1 << 8;
  localparam logic [17:0] M_GRB    = 18'h1 << 7;
  localparam logic [17:0] M_GRC    = 18'h1 << 6;
  localparam logic [17:0] M_BA     = 18'h1 << 5;
  localparam logic [17:0] M_PCSEL  = 18'h1 << 4;
  localparam logic [17:0] M_ZLO    = 18'h1 << 3;
  localparam logic [17:0] M_MDRSEL = 18'h1 << 2;
  localparam logic [17:0] M_CSEL   = 18'h1 << 1;
  localparam logic [17:0] M_RSEL   = 18'h1 << 0;

  logic        clk;
  logic        reset;
  logic [31:0] IR_Data;
  logic PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable;
  logic read, write, Gra, Grb, Grc, ba_select;
  logic PC_select, Z_LO_select, MDR_select, c_select, r_select;
  logic [4:0] alu_instruction;
  logic run, illegal_op;
  logic [3:0] state_T;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] act_w, exp_w;
  logic          chk_en;
  int            vec_cnt;
  int            err_cnt;

  control_unit #(.RESET_STATE(4'd0)) dut (
    .clk                 (clk),
    .reset               (reset),
    .IR_Data             (IR_Data),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .Grc                 (Grc),
    .ba_select           (ba_select),
    .PC_select           (PC_select),
    .Z_LO_select         (Z_LO_select),
    .MDR_select          (MDR_select),
    .c_select            (c_select),
    .r_select            (r_select),
    .alu_instruction     (alu_instruction),
    .run                 (run),
    .illegal_op          (illegal_op),
    .state_T             (state_T)
  );

  assign act_w = {state_T, run, illegal_op, alu_instruction,
                  PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                  MDR_enable, r_enable, read, write, Gra, Grb, Grc, ba_select,
                  PC_select, Z_LO_select, MDR_select, c_select, r_select};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ALU opcode from the opcode table
  function automatic logic [4:0] spec_alu(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: return 5'b00001;
      5'd4:                          return 5'b00100;
      5'd5, 5'd13:                   return 5'b01101;
      5'd6, 5'd14:                   return 5'b01110;
      default:                       return 5'b00000;
    endcase
  endfunction

  // Control word for step Tt (t = 0..7) while the machine is running
  function automatic logic [CW-1:0] cw(input int t, input logic [4:0] alu,
                                       input logic [17:0] en, input logic ill);
    return {4'(t + 1), 1'b1, ill, alu, en};
  endfunction

  // Queues the whole microstep sequence of one instruction; returns its length.
  function automatic int push_instr(input logic [4:0] op);
    logic [4:0] alu;
    int n;
    alu = spec_alu(op);
    exp_q.push_back(cw(0, 5'd0, M_PCSEL | M_MAR, 1'b0));
    exp_q.push_back(cw(1, 5'd0, M_PCI | M_RD | M_MDR, 1'b0));
    exp_q.push_back(cw(2, 5'd0, M_MDRSEL | M_IR, 1'b0));
    case (op)
      5'b00001, 5'b00000, 5'b00010: begin
        exp_q.push_back(cw(3, 5'd0, M_GRB | M_BA | M_Y, 1'b0));
        exp_q.push_back(cw(4, 5'b00001, M_CSEL | M_Z, 1'b0));
        if (op == 5'b00001) begin
          exp_q.push_back(cw(5, 5'd0, M_ZLO | M_GRA | M_REN, 1'b0));
          n = 6;
        end else begin
          exp_q.push_back(cw(5, 5'd0, M_ZLO | M_MAR, 1'b0));
          if (op == 5'b00000) begin
            exp_q.push_back(cw(6, 5'd0, M_RD | M_MDR, 1'b0));
            exp_q.push_back(cw(7, 5'd0, M_MDRSEL | M_GRA | M_REN, 1'b0));
          end else begin
            exp_q.push_back(cw(6, 5'd0, M_GRA | M_RSEL | M_MDR, 1'b0));
            exp_q.push_back(cw(7, 5'd0, M_WR, 1'b0));
          end
          n = 8;
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        exp_q.push_back(cw(3, 5'd0, M_GRB | M_RSEL | M_Y, 1'b0));
        exp_q.push_back(cw(4, alu, M_GRC | M_RSEL | M_Z, 1'b0));
        exp_q.push_back(cw(5, 5'd0, M_ZLO | M_GRA | M_REN, 1'b0));
        n = 6;
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_q.push_back(cw(3, 5'd0, M_CSEL | M_Y, 1'b0));
        exp_q.push_back(cw(4, alu, M_GRB | M_RSEL | M_Z, 1'b0));
        exp_q.push_back(cw(5, 5'd0, M_ZLO | M_GRA | M_REN, 1'b0));
        n = 6;
      end
      5'b11010, 5'b11011: begin
        exp_q.push_back(cw(3, 5'd0, 18'd0, 1'b0));
        n = 4;
      end
      default: begin
        exp_q.push_back(cw(3, 5'd0, 18'd0, 1'b1));
        n = 4;
      end
    endcase
    return n;
  endfunction

  function automatic void push_idle();
    exp_q.push_back('0);
  endfunction

  function automatic void push_halt();
    exp_q.push_back({4'd15, 25'd0});
  endfunction

  // Scoreboard compare, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        check("exp_underflow", 32'd1, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("ctrl_word", 32'(act_w), 32'(exp_w));
      end
      check("bus_exclusive",
            32'($countones({PC_select, Z_LO_select, MDR_select, c_select, r_select}) <= 1),
            32'd1);
    end
  end

  // Driver tasks: each returns just after a posedge, before the next compare.
  task automatic run_cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic start_instr(input logic [31:0] ir, output int n);
    IR_Data = ir;
    n = push_instr(ir[31:27]);
  endtask

  task automatic do_instr(input logic [31:0] ir);
    int n;
    start_instr(ir, n);
    run_cycles(n);
  endtask

  initial begin
    int n;
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    IR_Data = '0;
    chk_en  = 1'b1;

    // Reset held for 3 cycles, then one IDLE cycle before T0
    repeat (3) push_idle();
    run_cycles(3);
    check("reset_run", 32'(run), 32'd0);
    reset = 1'b0;
    run_cycles(1);
    check("t0_state", 32'(state_T), 32'd1);
    check("t0_fetch", 32'({PC_select, MAR_enable}), 32'h3);

    // ldi R2,0x65
    start_instr(32'h0900_0065, n);
    run_cycles(4);
    check("ldi_t4_alu", 32'(alu_instruction), 32'h01);
    check("ldi_t4_ctl", 32'({c_select, Z_enable}), 32'h3);
    run_cycles(1);
    check("ldi_t5_ctl", 32'({Gra, r_enable, Z_LO_select}), 32'h7);
    run_cycles(n - 5);
    check("ldi_len", 32'(state_T), 32'd1);

    // ori R3,R2,0x25
    start_instr(32'h7190_0025, n);
    run_cycles(3);
    check("ori_t3_ctl", 32'({c_select, Y_enable}), 32'h3);
    run_cycles(1);
    check("ori_t4_alu", 32'(alu_instruction), 32'h0E);
    check("ori_t4_ctl", 32'({Grb, r_select, Z_enable}), 32'h7);
    run_cycles(n - 4);
    check("ori_len", 32'(state_T), 32'd1);

    do_instr(32'h1180_0004);  // st
    do_instr(32'h0080_0010);  // ld
    do_instr(32'h1910_0000);  // add
    do_instr(32'h2110_0000);  // sub
    do_instr(32'h2910_0000);  // and
    do_instr(32'h3110_0000);  // or
    do_instr(32'h6110_0007);  // addi
    do_instr(32'h6910_0007);  // andi
    do_instr(32'hD000_0000);  // nop

    // Undefined opcode 10101
    start_instr(32'hA800_0000, n);
    run_cycles(3);
    check("ill_t3_pulse", 32'(illegal_op), 32'd1);
    run_cycles(1);
    check("ill_after", 32'({state_T, illegal_op}), 32'h2);
    do_instr(32'hF800_0000);  // undefined opcode 11111

    // Reset pulsed in T6 of ld
    start_instr(32'h0080_0010, n);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    run_cycles(6);
    reset = 1'b1;
    push_idle();
    #1;
    check("rst_async_state", 32'(state_T), 32'd0);
    check("rst_async_outs", 32'({read, MDR_enable, r_enable, write}), 32'd0);
    run_cycles(1);
    reset = 1'b0;
    push_idle();
    run_cycles(1);
    check("rst_restart_t0", 32'(state_T), 32'd1);
    do_instr(32'h0080_0010);

    // halt, then hold for 20 cycles
    start_instr(32'hD800_0000, n);
    repeat (20) push_halt();
    run_cycles(n + 20);
    check("halt_state", 32'(state_T), 32'd15);
    check("halt_run", 32'(run), 32'd0);
    chk_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
